// File: rtl/load_gather.sv
// load_gather: vector-load feeder for the register-load stage.
// Takes one request (base, count, optional stride), issues one element read
// per memory handshake and packs the in-order responses into LANES-wide
// single-cycle beats.
// Build option: define LOAD_GATHER_STRIDE_EN to add req_stride_i; without it
// the element stride is fixed at 1.
module load_gather #(
    parameter int NSIG   = 31,
    parameter int LANES  = 8,
    parameter int AW     = 32,
    parameter int MAXCNT = 64,
    parameter int CW     = $clog2(MAXCNT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [AW-1:0]             req_base_i,
    input  logic [CW-1:0]             req_count_i,
`ifdef LOAD_GATHER_STRIDE_EN
    input  logic [AW-1:0]             req_stride_i,
`endif
    output logic                      mem_valid_o,
    input  logic                      mem_ready_i,
    output logic [AW-1:0]             mem_addr_o,
    input  logic                      rsp_valid_i,
    input  logic [NSIG:0]             rsp_data_i,
    output logic                      beat_valid_o,
    output logic [LANES-1:0][NSIG:0]  beat_data_o,
    output logic [LANES-1:0]          beat_mask_o,
    output logic                      beat_last_o,
    output logic                      busy_o
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [AW-1:0]            addr_q;
    logic [AW-1:0]            stride_q;
    logic [CW-1:0]            count_q;
    logic [CW-1:0]            issued_q;
    logic [CW-1:0]            recv_q;
    logic [LW-1:0]            lane_q;
    logic [LANES-1:0][NSIG:0] acc_q;
    logic [LANES-1:0]         mask_q;
    logic [LANES-1:0][NSIG:0] acc_ins;
    logic [LANES-1:0]         mask_ins;
    logic [CW-1:0]            cnt_clamp;
    logic                     req_fire;
    logic                     start;
    logic                     issue_fire;
    logic                     rsp_take;
    logic                     rsp_final;
    logic                     beat_emit;

    // Request acceptance; oversized counts clamp, zero counts are a no-op
    assign req_ready_o = (state_q == IDLE) && !rst;
    assign req_fire    = req_valid_i && req_ready_o;
    assign cnt_clamp   = (req_count_i > CW'(MAXCNT)) ? CW'(MAXCNT) : req_count_i;
    assign start       = req_fire && (cnt_clamp != '0);

    // Issue side: address register advances by stride, so it holds while stalled
    assign busy_o      = (state_q == RUN);
    assign mem_valid_o = (state_q == RUN) && (issued_q != count_q);
    assign mem_addr_o  = addr_q;
    assign issue_fire  = mem_valid_o && mem_ready_i;

    // Receive side: responses beyond count or while idle are dropped
    assign rsp_take  = (state_q == RUN) && rsp_valid_i && (recv_q != count_q);
    assign rsp_final = rsp_take && (recv_q == (count_q - CW'(1)));
    assign beat_emit = rsp_take && ((lane_q == LW'(LANES - 1)) || rsp_final);

`ifdef LOAD_GATHER_STRIDE_EN
    // Latch the stride with the request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride_q <= '0;
        end else if (start) begin
            stride_q <= req_stride_i;
        end
    end
`else
    assign stride_q = AW'(1);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: RUN on a non-empty request, back to IDLE on the final response
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (rsp_final) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address, issue and receive counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            count_q  <= '0;
            issued_q <= '0;
            recv_q   <= '0;
            lane_q   <= '0;
        end else if (start) begin
            addr_q   <= req_base_i;
            count_q  <= cnt_clamp;
            issued_q <= '0;
            recv_q   <= '0;
            lane_q   <= '0;
        end else begin
            if (issue_fire) begin
                addr_q   <= addr_q + stride_q;
                issued_q <= issued_q + 1'b1;
            end
            if (rsp_take) begin
                recv_q <= recv_q + 1'b1;
                lane_q <= (lane_q == LW'(LANES - 1)) ? '0 : lane_q + 1'b1;
            end
        end
    end

    // Accumulator view with the incoming element already inserted
    always_comb begin
        acc_ins          = acc_q;
        mask_ins         = mask_q;
        acc_ins[lane_q]  = rsp_data_i;
        mask_ins[lane_q] = 1'b1;
    end

    // Stage p0: accumulate elements, clearing whenever a beat leaves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            mask_q <= '0;
        end else if (beat_emit) begin
            acc_q  <= '0;
            mask_q <= '0;
        end else if (rsp_take) begin
            acc_q  <= acc_ins;
            mask_q <= mask_ins;
        end
    end

    // Stage p1: registered one-cycle beat to the register-load stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_valid_o <= 1'b0;
            beat_last_o  <= 1'b0;
            beat_data_o  <= '0;
            beat_mask_o  <= '0;
        end else begin
            beat_valid_o <= beat_emit;
            beat_last_o  <= rsp_final;
            if (beat_emit) begin
                beat_data_o <= acc_ins;
                beat_mask_o <= mask_ins;
            end
        end
    end

endmodule

// File: tb/tb_load_gather.sv
// tb_load_gather: directed bench for load_gather with a queue-based model of
// expected addresses and beats, an in-order memory responder, and a per-cycle
// compare process.
`timescale 1ns/1ps
module tb_load_gather;

    localparam int NSIG   = 31;
    localparam int DW     = NSIG + 1;
    localparam int LANES  = 8;
    localparam int AW     = 32;
    localparam int MAXCNT = 64;
    localparam int CW     = $clog2(MAXCNT + 1);
    localparam int BW     = LANES * DW;

    typedef struct {
        logic [LANES-1:0][NSIG:0] data;
        logic [LANES-1:0]         mask;
        logic                     last;
    } beat_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     req_valid_i;
    logic                     req_ready_o;
    logic [AW-1:0]            req_base_i;
    logic [CW-1:0]            req_count_i;
    logic [AW-1:0]            req_stride_i;
    logic                     mem_valid_o;
    logic                     mem_ready_i;
    logic [AW-1:0]            mem_addr_o;
    logic                     rsp_valid_i;
    logic [NSIG:0]            rsp_data_i;
    logic                     beat_valid_o;
    logic [LANES-1:0][NSIG:0] beat_data_o;
    logic [LANES-1:0]         beat_mask_o;
    logic                     beat_last_o;
    logic                     busy_o;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0]            exp_addr[$];
    beat_t                    exp_beats[$];
    logic [AW-1:0]            got_addr[$];
    int                       n_beats = 0;
    logic [LANES-1:0][NSIG:0] last_data = '0;
    logic [LANES-1:0]         last_mask = '0;

    logic [NSIG:0]            tag = '0;
    int                       rsp_idx = 0;
    int                       rsp_cnt = 0;
    bit                       alt_ready = 1'b0;

    always #5 clk = ~clk;

    load_gather #(
        .NSIG(NSIG), .LANES(LANES), .AW(AW), .MAXCNT(MAXCNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_base_i(req_base_i),
        .req_count_i(req_count_i),
`ifdef LOAD_GATHER_STRIDE_EN
        .req_stride_i(req_stride_i),
`endif
        .mem_valid_o(mem_valid_o),
        .mem_ready_i(mem_ready_i),
        .mem_addr_o(mem_addr_o),
        .rsp_valid_i(rsp_valid_i),
        .rsp_data_i(rsp_data_i),
        .beat_valid_o(beat_valid_o),
        .beat_data_o(beat_data_o),
        .beat_mask_o(beat_mask_o),
        .beat_last_o(beat_last_o),
        .busy_o(busy_o)
    );

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: one in-order response per accepted read, one cycle later
    initial begin
        bit            pend;
        logic [NSIG:0] pend_data;
        rsp_valid_i = 1'b0;
        rsp_data_i  = '0;
        mem_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            pend      = !rst && mem_valid_o && mem_ready_i;
            pend_data = tag + DW'(rsp_idx);
            if (pend) rsp_idx++;
            @(posedge clk);
            #1;
            rsp_valid_i = pend;
            rsp_data_i  = pend ? pend_data : '0;
            if (pend) rsp_cnt++;
            mem_ready_i = alt_ready ? !mem_ready_i : 1'b1;
        end
    end

    // Compare process: issues, stall stability and beats against the model
    initial begin
        bit            stall_prev = 1'b0;
        logic [AW-1:0] stall_addr = '0;
        beat_t         eb;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_hold_valid", mem_valid_o, 1'b1);
                    check("stall_hold_addr", mem_addr_o, stall_addr);
                end
                if (mem_valid_o && mem_ready_i) begin
                    check("issue_expected", exp_addr.size() > 0, 1'b1);
                    if (exp_addr.size() > 0) check("issue_addr", mem_addr_o, exp_addr.pop_front());
                    got_addr.push_back(mem_addr_o);
                end
                stall_prev = mem_valid_o && !mem_ready_i;
                stall_addr = mem_addr_o;
                if (beat_valid_o) begin
                    n_beats++;
                    last_data = beat_data_o;
                    last_mask = beat_mask_o;
                    check("beat_expected", exp_beats.size() > 0, 1'b1);
                    if (exp_beats.size() > 0) begin
                        eb = exp_beats.pop_front();
                        check("beat_data", beat_data_o, eb.data);
                        check("beat_mask", beat_mask_o, eb.mask);
                        check("beat_last", beat_last_o, eb.last);
                        if (eb.last) begin
                            check("ready_with_last", req_ready_o, 1'b1);
                            check("idle_with_last", busy_o, 1'b0);
                        end
                    end
                end else begin
                    check("no_stray_last", beat_last_o, 1'b0);
                end
            end
        end
    end

    // Build the expected addresses and beats for a request, then submit it
    task automatic do_req(input logic [AW-1:0] base, input int cnt, input logic [AW-1:0] stride,
                          input bit alt, input logic [NSIG:0] t, input bit wait_done);
        int    n;
        int    cyc;
        beat_t b;
        n = (cnt > MAXCNT) ? MAXCNT : cnt;
`ifndef LOAD_GATHER_STRIDE_EN
        stride = AW'(1);
`endif
        tag       = t;
        rsp_idx   = 0;
        alt_ready = alt;
        n_beats   = 0;
        got_addr.delete();
        for (int i = 0; i < n; i++) exp_addr.push_back(base + AW'(i) * stride);
        for (int k = 0; k * LANES < n; k++) begin
            b.data = '0;
            b.mask = '0;
            for (int j = 0; j < LANES; j++) begin
                if (k * LANES + j < n) begin
                    b.data[j] = t + DW'(k * LANES + j);
                    b.mask[j] = 1'b1;
                end
            end
            b.last = ((k + 1) * LANES >= n);
            exp_beats.push_back(b);
        end
        check("ready_before_req", req_ready_o, 1'b1);
        req_base_i   = base;
        req_count_i  = CW'(cnt);
        req_stride_i = stride;
        req_valid_i  = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        if (wait_done) begin
            cyc = 0;
            while ((exp_beats.size() != 0 || busy_o) && cyc < 1000) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check("req_done_in_time", cyc < 1000, 1'b1);
            check("all_issued", exp_addr.size(), 0);
            alt_ready = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int cyc;
        rst          = 1'b1;
        req_valid_i  = 1'b0;
        req_base_i   = '0;
        req_count_i  = '0;
        req_stride_i = '0;
        #3;
        check("rst_req_ready", req_ready_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_mem_valid", mem_valid_o, 1'b0);
        check("rst_beat_valid", beat_valid_o, 1'b0);
        check("rst_beat_last", beat_last_o, 1'b0);
        check("rst_beat_data", beat_data_o, '0);
        check("rst_beat_mask", beat_mask_o, '0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", req_ready_o, 1'b1);

        // Eight contiguous elements, data equals element index
        do_req(32'h100, 8, 32'h1, 1'b0, 32'h0, 1'b1);
        check("t1_addr0", got_addr[0], 32'h100);
        check("t1_addr7", got_addr[7], 32'h107);
        check("t1_beats", n_beats, 1);
        check("t1_mask", last_mask, 8'hFF);
        check("t1_lane5", last_data[5], 32'h5);

        // Eleven elements: full beat then a three-lane final beat
        do_req(32'h200, 11, 32'h1, 1'b0, 32'h200, 1'b1);
        check("t2_beats", n_beats, 2);
        check("t2_mask", last_mask, 8'h07);
        check("t2_lane2", last_data[2], 32'h20A);
        check("t2_lane3", last_data[3], 32'h0);

        // Alternating memory ready
        do_req(32'h300, 8, 32'h1, 1'b1, 32'h3000, 1'b1);
        check("t3_issues", got_addr.size(), 8);
        check("t3_addr7", got_addr[7], 32'h307);
        check("t3_lane7", last_data[7], 32'h3007);

`ifdef LOAD_GATHER_STRIDE_EN
        // Stride with address wrap
        do_req(32'hFFFF_FFF8, 4, 32'h4, 1'b0, 32'h500, 1'b1);
        check("st_addr1", got_addr[1], 32'hFFFF_FFFC);
        check("st_addr2", got_addr[2], 32'h0);
        check("st_addr3", got_addr[3], 32'h4);
        check("st_mask", last_mask, 8'h0F);
`endif

        // Zero count is accepted but does nothing
        do_req(32'h600, 0, 32'h1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("zero_busy", busy_o, 1'b0);
            check("zero_mem_valid", mem_valid_o, 1'b0);
            @(posedge clk);
            #1;
        end
        check("zero_no_beat", n_beats, 0);

        // Oversized count clamps to MAXCNT
        do_req(32'h1000, 100, 32'h1, 1'b0, 32'h7000, 1'b1);
        check("clamp_issues", got_addr.size(), 64);
        check("clamp_beats", n_beats, 8);
        check("clamp_addr63", got_addr[63], 32'h103F);

        // Reset in the middle of a request
        rsp_cnt = 0;
        do_req(32'h400, 16, 32'h1, 1'b0, 32'h4000, 1'b0);
        cyc = 0;
        while (rsp_cnt < 3 && cyc < 100) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check("mid_rst_reached", rsp_cnt >= 3, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_mem_valid", mem_valid_o, 1'b0);
        check("mid_rst_beat_valid", beat_valid_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_mask", beat_mask_o, '0);
        check("mid_rst_no_beat", n_beats, 0);
        exp_addr.delete();
        exp_beats.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("post_rst_ready", req_ready_o, 1'b1);
        @(posedge clk);
        #1;
        do_req(32'h800, 8, 32'h1, 1'b0, 32'h8000, 1'b1);
        check("post_rst_beats", n_beats, 1);
        check("post_rst_mask", last_mask, 8'hFF);
        check("post_rst_lane0", last_data[0], 32'h8000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
